ucode_sequencer: RTL and testbench

- Consumer side of the microcode store: accepts a complex-instruction request carrying an entry micro-PC, walks the microcode ROM from that entry, and issues one resolved microinstruction per handshake until the word flagged uend.
- Resolves the indirection bits in each ROM word against the original macro-instruction.
- Sits between decode and the issue stage; the ROM itself is external, with synchronous read and 1-cycle latency.

---
 rtl/ucode_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_ucode_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ucode_sequencer.sv
// Microcode sequencer: takes a complex-instruction request with an entry
// micro-PC, walks the external synchronous microcode ROM from that entry and
// issues one resolved microinstruction per output handshake until the word
// flagged uend, a length overrun or the last micro-PC ends the sequence.
// Optional build macro: UCODE_STAT_EN adds saturating sequence/word counters.
module ucode_sequencer #(
    parameter int NUPCMSB = 4,
    parameter int NTIDMSB = 5,
    parameter int UMAXLEN = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [NUPCMSB:0]   req_upc,
    input  logic [31:0]        req_inst,
    input  logic [NTIDMSB:0]   req_tid,
    input  logic               abort,
    output logic               rom_en,
    output logic [NUPCMSB:0]   rom_addr,
    input  logic [34:0]        rom_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_inst,
    output logic               out_cwp_rs1,
    output logic               out_cwp_rd,
    output logic               out_last,
    output logic [NTIDMSB:0]   out_tid,
    output logic [NUPCMSB:0]   out_upc,
`ifdef UCODE_STAT_EN
    output logic [15:0]        stat_seq,
    output logic [15:0]        stat_word,
`endif
    output logic               err
);

    localparam int CW = $clog2(UMAXLEN + 1);
    localparam logic [NUPCMSB:0] UPC_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ISSUE} state_t;

    state_t           state_q, state_d;
    logic [NUPCMSB:0] upc_q;
    logic [CW-1:0]    len_q;
    logic [CW-1:0]    len_next;
    logic [31:0]      macro_q;
    logic [NTIDMSB:0] tid_q;
    logic [31:0]      resolved;
    logic             hit_len;
    logic             hit_upc;
    logic             word_last;
    logic             handshake;

    assign req_ready = (state_q == S_IDLE);
    assign out_valid = (state_q == S_ISSUE);
    assign out_tid   = tid_q;
    assign out_upc   = upc_q;
    assign handshake = (state_q == S_ISSUE) && out_ready && !abort;

    // Word-level decisions for the ROM data arriving this cycle: a sequence is
    // cut short at the length limit or at the top of the micro-PC space.
    assign len_next  = len_q + 1'b1;
    assign hit_len   = (len_next == CW'(UMAXLEN));
    assign hit_upc   = (upc_q == UPC_MAX);
    assign word_last = rom_data[34] | hit_len | hit_upc;

    // Substitute macro-instruction register fields where the ROM word asks for them.
    always_comb begin
        resolved = rom_data[31:0];
        if (rom_data[29]) begin
            resolved[29:25] = macro_q[29:25];
        end
        if (rom_data[18]) begin
            resolved[18:14] = macro_q[18:14];
        end
        if (!rom_data[13] && rom_data[4]) begin
            resolved[4:0] = macro_q[4:0];
        end
    end

    // Next state and ROM read strobe; abort wins over everything outside IDLE.
    always_comb begin
        state_d  = state_q;
        rom_en   = 1'b0;
        rom_addr = '0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    rom_en   = 1'b1;
                    rom_addr = req_upc;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                state_d = abort ? S_IDLE : S_ISSUE;
            end
            S_ISSUE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (out_ready) begin
                    if (out_last) begin
                        state_d = S_IDLE;
                    end else begin
                        rom_en   = 1'b1;
                        rom_addr = upc_q + 1'b1;
                        state_d  = S_WAIT;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request latching, output word capture, micro-PC advance and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upc_q       <= '0;
            len_q       <= '0;
            macro_q     <= '0;
            tid_q       <= '0;
            out_inst    <= '0;
            out_cwp_rs1 <= 1'b0;
            out_cwp_rd  <= 1'b0;
            out_last    <= 1'b0;
            err         <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        macro_q <= req_inst;
                        tid_q   <= req_tid;
                        upc_q   <= req_upc;
                        len_q   <= '0;
                    end
                end
                S_WAIT: begin
                    if (!abort) begin
                        out_inst    <= resolved;
                        out_cwp_rs1 <= rom_data[33];
                        out_cwp_rd  <= rom_data[32];
                        out_last    <= word_last;
                        len_q       <= len_next;
                        if (!rom_data[34] && (hit_len || hit_upc)) begin
                            err <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (handshake && !out_last) begin
                        upc_q <= upc_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef UCODE_STAT_EN
    // Saturating counters of issued words and completed sequences.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_seq  <= '0;
            stat_word <= '0;
        end else if (handshake) begin
            if (stat_word != 16'hFFFF) begin
                stat_word <= stat_word + 16'd1;
            end
            if (out_last && (stat_seq != 16'hFFFF)) begin
                stat_seq <= stat_seq + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ucode_sequencer.sv
// Directed bench for ucode_sequencer with a ROM model and an expected-word
// scoreboard; covers resolution, stalls, length/wrap termination, abort and reset.
module tb_ucode_sequencer;

    typedef struct {
        logic [31:0] inst;
        logic        rs1;
        logic        rd;
        logic        last;
        logic [4:0]  upc;
        logic [5:0]  tid;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  req_upc = '0;
    logic [31:0] req_inst = '0;
    logic [5:0]  req_tid = '0;
    logic        abort = 1'b0;
    logic        rom_en;
    logic [4:0]  rom_addr;
    logic [34:0] rom_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic        out_cwp_rs1;
    logic        out_cwp_rd;
    logic        out_last;
    logic [5:0]  out_tid;
    logic [4:0]  out_upc;
    logic        err;
`ifdef UCODE_STAT_EN
    logic [15:0] stat_seq;
    logic [15:0] stat_word;
`endif

    logic [34:0] rom [32];
    exp_t        sb [$];
    int          checks = 0;
    int          fails = 0;
    logic        model_err = 1'b0;
    int          model_seq = 0;
    int          model_word = 0;

    ucode_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_upc     (req_upc),
        .req_inst    (req_inst),
        .req_tid     (req_tid),
        .abort       (abort),
        .rom_en      (rom_en),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_inst    (out_inst),
        .out_cwp_rs1 (out_cwp_rs1),
        .out_cwp_rd  (out_cwp_rd),
        .out_last    (out_last),
        .out_tid     (out_tid),
        .out_upc     (out_upc),
`ifdef UCODE_STAT_EN
        .stat_seq    (stat_seq),
        .stat_word   (stat_word),
`endif
        .err         (err)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Synchronous-read ROM with one cycle of latency.
    always @(posedge clk) begin
        if (rom_en) begin
            rom_data <= rom[rom_addr];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] model_resolve(input logic [31:0] w, input logic [31:0] mi);
        logic [31:0] r;
        r = w;
        if (w[29]) r[29:25] = mi[29:25];
        if (w[18]) r[18:14] = mi[18:14];
        if (w[13] == 1'b0 && w[4] == 1'b1) r[4:0] = mi[4:0];
        return r;
    endfunction

    task automatic push_word(input logic [31:0] inst, input logic rs1, input logic rd,
                             input logic last, input logic [4:0] upc, input logic [5:0] tid,
                             input logic e);
        exp_t x;
        x.inst = inst; x.rs1 = rs1; x.rd = rd; x.last = last;
        x.upc = upc; x.tid = tid; x.err = e;
        sb.push_back(x);
    endtask

    // Walk the ROM image the way the sequence should, including forced ends.
    task automatic build_expected(input logic [4:0] upc0, input logic [31:0] mi, input logic [5:0] tid);
        int   u;
        int   len;
        logic forced;
        logic last;
        u = upc0;
        len = 0;
        for (int n = 0; n < 32; n++) begin
            len++;
            forced = (len == 8) || (u == 31);
            last = rom[u][34] || forced;
            if (forced && !rom[u][34]) model_err = 1'b1;
            push_word(model_resolve(rom[u][31:0], mi), rom[u][33], rom[u][32], last,
                      5'(u), tid, model_err);
            if (last) break;
            u++;
        end
    endtask

    task automatic applyStimulus(input logic [4:0] upc, input logic [31:0] mi, input logic [5:0] tid);
        @(negedge clk);
        req_valid = 1'b1;
        req_upc = upc;
        req_inst = mi;
        req_tid = tid;
        #1;
        checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
        checkOutput("req_rom_addr", {26'd0, rom_en, rom_addr}, {26'd0, 1'b1, upc});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Consume one whole sequence from the DUT, comparing each word against the scoreboard.
    task automatic drain(input int stall);
        exp_t e;
        int   st;
        bit   done;
        st = stall;
        done = 0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            @(negedge clk);
            if (out_valid) begin
                if (sb.size() == 0) begin
                    checks++; fails++;
                    $error("[TB] FAIL scoreboard_empty observed=word expected=none");
                    done = 1;
                end else begin
                    e = sb[0];
                    checkOutput("out_inst", out_inst, e.inst);
                    checkOutput("out_ctl",
                        32'({out_cwp_rs1, out_cwp_rd, out_last, out_upc, out_tid, err}),
                        32'({e.rs1, e.rd, e.last, e.upc, e.tid, e.err}));
                    if (st > 0) begin
                        out_ready = 1'b0;
                        st--;
                    end else begin
                        out_ready = 1'b1;
                        #1;
                        if (e.last) begin
                            checkOutput("last_no_fetch", {30'd0, rom_en, req_ready}, 32'd0);
                        end else begin
                            checkOutput("next_fetch", {26'd0, rom_en, rom_addr}, {26'd0, 1'b1, e.upc + 5'd1});
                        end
                        void'(sb.pop_front());
                        model_word++;
                        if (e.last) begin
                            model_seq++;
                            @(negedge clk);
                            out_ready = 1'b0;
                            checkOutput("idle_after_last", {30'd0, req_ready, out_valid}, 32'd2);
                            done = 1;
                        end
                    end
                end
            end else begin
                out_ready = 1'b0;
            end
        end
        if (!done) begin
            checks++; fails++;
            $error("[TB] FAIL drain_timeout observed=no_last expected=last");
        end
        out_ready = 1'b0;
    endtask

    initial begin
        $display("[TB] ucode_sequencer bench start");
        for (int i = 0; i < 32; i++) begin
            rom[i] = {1'b1, 2'(i), $urandom()};
        end

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_ctl", {25'd0, req_ready, out_valid, rom_en, err, out_last, out_cwp_rs1, out_cwp_rd},
                    32'h40);
        checkOutput("reset_data", out_inst | 32'(rom_addr) | 32'(out_upc) | 32'(out_tid), 32'd0);
        rst = 1'b0;

        // Single-word sequence with rd substitution.
        rom[4] = {1'b1, 1'b0, 1'b0, 32'hF020_0000};
        push_word(32'hCA20_0000, 1'b0, 1'b0, 1'b1, 5'd4, 6'd3, 1'b0);
        applyStimulus(5'd4, 32'h0A00_0000, 6'd3);
        drain(0);

        // Two-word STD sequence with a three-cycle stall on the first word.
        rom[7] = {1'b0, 1'b1, 1'b0, 32'h2004_0015};
        rom[8] = {1'b1, 1'b0, 1'b1, 32'h0000_4010};
        build_expected(5'd7, 32'h3A5C_4C1F, 6'd17);
        applyStimulus(5'd7, 32'h3A5C_4C1F, 6'd17);
        drain(3);

        // Immediate form leaves the rs2 bits alone; register form takes them.
        rom[20] = {1'b1, 1'b0, 1'b0, 32'h8000_2013};
        push_word(32'h8000_2013, 1'b0, 1'b0, 1'b1, 5'd20, 6'd1, 1'b0);
        applyStimulus(5'd20, 32'h0000_0003, 6'd1);
        drain(0);
        rom[20] = {1'b1, 1'b0, 1'b0, 32'h8000_0013};
        push_word(32'h8000_0003, 1'b0, 1'b0, 1'b1, 5'd20, 6'd2, 1'b0);
        applyStimulus(5'd20, 32'h0000_0003, 6'd2);
        drain(0);

        // Abort while waiting on the ROM, then a fresh request issues normally.
        rom[9] = {1'b0, 1'b0, 1'b0, 32'h1111_0000};
        applyStimulus(5'd9, 32'h0000_0000, 6'd5);
        abort = 1'b1;
        #1;
        checkOutput("abort_wait_rom_en", 32'(rom_en), 32'd0);
        @(posedge clk);
        #1;
        abort = 1'b0;
        checkOutput("after_abort", {29'd0, out_valid, rom_en, req_ready}, 32'd1);
        rom[13] = {1'b1, 1'b1, 1'b1, 32'h2404_0011};
        build_expected(5'd13, 32'hFFFF_FFFF, 6'd6);
        applyStimulus(5'd13, 32'hFFFF_FFFF, 6'd6);
        drain(0);

        // Runaway sequence is cut at the length limit and flags the error.
        for (int i = 9; i < 32; i++) rom[i][34] = 1'b0;
        build_expected(5'd9, 32'h1234_5678, 6'd9);
        applyStimulus(5'd9, 32'h1234_5678, 6'd9);
        drain(0);
        checkOutput("err_sticky", 32'(err), 32'd1);
`ifdef UCODE_STAT_EN
        checkOutput("stat_word", 32'(stat_word), 32'(model_word));
        checkOutput("stat_seq", 32'(stat_seq), 32'(model_seq));
`endif

        // Reset in the middle of an issued word.
        applyStimulus(5'd2, 32'h0, 6'd7);
        for (int i = 0; i < 10 && !out_valid; i++) @(negedge clk);
        checkOutput("pre_reset_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("mid_reset_ctl", {26'd0, req_ready, out_valid, rom_en, err, out_last, out_cwp_rs1},
                    32'h20);
        checkOutput("mid_reset_data", out_inst | 32'(rom_addr) | 32'(out_upc) | 32'(out_tid), 32'd0);
`ifdef UCODE_STAT_EN
        checkOutput("stat_reset", {stat_seq, stat_word}, 32'd0);
`endif
        sb.delete();
        model_err = 1'b0;
        model_seq = 0;
        model_word = 0;
        @(negedge clk);
        rst = 1'b0;

        // Sequence running into the last micro-PC is forced to end there.
        rom[30] = {1'b0, 1'b0, 1'b1, 32'h2000_0010};
        rom[31] = {1'b0, 1'b1, 1'b0, 32'h0004_0000};
        build_expected(5'd30, 32'h5555_AAAA, 6'd33);
        applyStimulus(5'd30, 32'h5555_AAAA, 6'd33);
        drain(1);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
